simon_button_conditioner: RTL and testbench

Conditions the four raw Simon colour push-buttons into clean, single-cycle press events. Synchronises (optionally) and debounces the raw pins, rejects simultaneous multi-button presses, and emits one one-hot press pulse per physical press. Sits directly upstream of the 1-bit latch/flip-flop storage: `press` drives the latch set inputs, and game control drives the reset inputs.

---
 rtl/simon_button_conditioner.sv | 166 ++++++++++++++++
 tb/tb_simon_button_conditioner.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/simon_button_conditioner.sv
// Debounces the four Simon colour buttons and emits one one-hot press pulse per physical press.
// Optional 2-flop input synchroniser enabled by defining SIMON_BTN_SYNC_EN.
module simon_button_conditioner #(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic               en,
    output logic [NUM_BTN-1:0] press,
    output logic               press_valid,
    output logic [1:0]         press_code,
    output logic               multi_err,
    output logic               held
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_QUAL = 2'd1,
        ST_HELD = 2'd2,
        ST_REL  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic is_one_hot(input logic [NUM_BTN-1:0] v);
        logic [7:0] ones;
        ones = 8'd0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (v[i]) begin
                ones = ones + 8'd1;
            end
        end
        return (ones == 8'd1);
    endfunction

    function automatic logic [1:0] one_hot_index(input logic [NUM_BTN-1:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (v[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

    logic [NUM_BTN-1:0] samp_s;

`ifdef SIMON_BTN_SYNC_EN
    logic [NUM_BTN-1:0] sync1_q;
    logic [NUM_BTN-1:0] sync2_q;

    // Two-flop synchroniser bringing the asynchronous pins into the clk domain.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    assign samp_s = sync2_q;
`else
    assign samp_s = btn_raw;
`endif

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [NUM_BTN-1:0] cand_q;
    logic [NUM_BTN-1:0] press_q;
    logic               press_valid_q;
    logic [1:0]         press_code_q;
    logic               multi_err_q;
    logic               held_q;

    // Debounce FSM with registered one-cycle event outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            cand_q        <= '0;
            press_q       <= '0;
            press_valid_q <= 1'b0;
            press_code_q  <= 2'd0;
            multi_err_q   <= 1'b0;
            held_q        <= 1'b0;
        end else begin
            press_q       <= '0;
            press_valid_q <= 1'b0;
            press_code_q  <= 2'd0;
            multi_err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    held_q <= 1'b0;
                    cnt_q  <= '0;
                    if (samp_s != '0) begin
                        cand_q  <= samp_s;
                        cnt_q   <= CNT_ONE;
                        state_q <= ST_QUAL;
                    end
                end
                ST_QUAL: begin
                    held_q <= 1'b0;
                    if (samp_s != cand_q) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else if (cnt_q >= CNT_LAST) begin
                        // en only matters on this accepting edge; multi_err is never masked.
                        cnt_q   <= '0;
                        held_q  <= 1'b1;
                        state_q <= ST_HELD;
                        if (!is_one_hot(cand_q)) begin
                            multi_err_q <= 1'b1;
                        end else if (en) begin
                            press_q       <= cand_q;
                            press_valid_q <= 1'b1;
                            press_code_q  <= one_hot_index(cand_q);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_HELD: begin
                    held_q <= 1'b1;
                    if (samp_s == '0) begin
                        cnt_q   <= CNT_ONE;
                        state_q <= ST_REL;
                    end
                end
                ST_REL: begin
                    if (samp_s != '0) begin
                        cnt_q   <= '0;
                        held_q  <= 1'b1;
                        state_q <= ST_HELD;
                    end else if (cnt_q >= CNT_LAST) begin
                        cnt_q   <= '0;
                        held_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        held_q <= 1'b1;
                        cnt_q  <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    cand_q  <= '0;
                    held_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign press       = press_q;
    assign press_valid = press_valid_q;
    assign press_code  = press_code_q;
    assign multi_err   = multi_err_q;
    assign held        = held_q;

endmodule

// File: tb/tb_simon_button_conditioner.sv
// Directed bench for simon_button_conditioner (DEBOUNCE_CYCLES=4); expected timing shifts by
// two edges when SIMON_BTN_SYNC_EN is defined.
module tb_simon_button_conditioner;

    localparam int D = 4;
`ifdef SIMON_BTN_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       resetn;
    logic [3:0] btn_raw;
    logic       en;
    logic [3:0] press;
    logic       press_valid;
    logic [1:0] press_code;
    logic       multi_err;
    logic       held;

    int checks = 0;
    int errors = 0;
    int pv_cnt = 0;
    int me_cnt = 0;
    int overlap_cnt = 0;
    int wide_cnt = 0;
    logic pv_prev = 1'b0;
    logic me_prev = 1'b0;

    simon_button_conditioner #(
        .NUM_BTN(4),
        .DEBOUNCE_CYCLES(D),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .btn_raw(btn_raw),
        .en(en),
        .press(press),
        .press_valid(press_valid),
        .press_code(press_code),
        .multi_err(multi_err),
        .held(held)
    );

    always #5 clk = ~clk;

    // Pulse bookkeeping sampled mid-cycle.
    always @(negedge clk) begin
        if (press_valid) pv_cnt <= pv_cnt + 1;
        if (multi_err) me_cnt <= me_cnt + 1;
        if (press_valid && multi_err) overlap_cnt <= overlap_cnt + 1;
        if ((press_valid && pv_prev) || (multi_err && me_prev)) wide_cnt <= wide_cnt + 1;
        pv_prev <= press_valid;
        me_prev <= multi_err;
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_event(input string tag, input logic [3:0] vec, input logic [1:0] code);
        chk({tag, "_press"}, {28'd0, press}, {28'd0, vec});
        chk({tag, "_valid"}, {31'd0, press_valid}, 32'd1);
        chk({tag, "_code"}, {30'd0, press_code}, {30'd0, code});
        chk({tag, "_held"}, {31'd0, held}, 32'd1);
        chk({tag, "_merr"}, {31'd0, multi_err}, 32'd0);
    endtask

    initial begin
        int pv_base;
        resetn  = 1'b0;
        btn_raw = 4'b0000;
        en      = 1'b1;
        step(3);
        chk("reset_outputs", {24'd0, press, press_valid, press_code, multi_err, held}, 32'd0);
        resetn = 1'b1;
        step(5);

        // Scenario 1: basic press of button 2 and full release.
        btn_raw = 4'b0100;
        step(D - 1 + LAT);
        chk("s1_early_valid", {31'd0, press_valid}, 32'd0);
        chk("s1_early_held", {31'd0, held}, 32'd0);
        step(1);
        chk_event("s1", 4'b0100, 2'd2);
        step(1);
        chk("s1_pulse_end", {31'd0, press_valid}, 32'd0);
        chk("s1_still_held", {31'd0, held}, 32'd1);
        step(6);
        btn_raw = 4'b0000;
        step(D - 1 + LAT);
        chk("s1_rel_held", {31'd0, held}, 32'd1);
        step(1);
        chk("s1_rel_done", {31'd0, held}, 32'd0);
        step(3);

        // Scenario 2: bouncing button 0, then stable.
        pv_base = pv_cnt;
        for (int k = 0; k < 5; k++) begin
            btn_raw = 4'b0001;
            step(2);
            btn_raw = 4'b0000;
            step(2);
        end
        chk("s2_no_bounce_event", pv_cnt, pv_base);
        chk("s2_no_bounce_held", {31'd0, held}, 32'd0);
        btn_raw = 4'b0001;
        step(D - 1 + LAT);
        chk("s2_early_valid", {31'd0, press_valid}, 32'd0);
        step(1);
        chk_event("s2", 4'b0001, 2'd0);
        // Release bounce while HELD must not create another event.
        step(3);
        btn_raw = 4'b0000;
        step(2);
        btn_raw = 4'b0001;
        step(3);
        btn_raw = 4'b0000;
        step(D + LAT + 2);
        chk("s2_single_event", pv_cnt, pv_base + 1);
        chk("s2_released", {31'd0, held}, 32'd0);

        // Scenario 3: two buttons together.
        btn_raw = 4'b0011;
        step(D - 1 + LAT);
        chk("s3_early_merr", {31'd0, multi_err}, 32'd0);
        step(1);
        chk("s3_merr", {31'd0, multi_err}, 32'd1);
        chk("s3_no_valid", {31'd0, press_valid}, 32'd0);
        chk("s3_held", {31'd0, held}, 32'd1);
        step(1);
        chk("s3_merr_end", {31'd0, multi_err}, 32'd0);
        btn_raw = 4'b0000;
        step(D + LAT + 2);

        // Scenario 4: en low swallows the press, then a real one with en high.
        en = 1'b0;
        btn_raw = 4'b1000;
        step(D + LAT);
        chk("s4_swallowed", {31'd0, press_valid}, 32'd0);
        chk("s4_swallow_held", {31'd0, held}, 32'd1);
        btn_raw = 4'b0000;
        step(D + LAT + 2);
        en = 1'b1;
        btn_raw = 4'b1000;
        step(D - 1 + LAT);
        chk("s4_early_valid", {31'd0, press_valid}, 32'd0);
        step(1);
        chk_event("s4", 4'b1000, 2'd3);
        btn_raw = 4'b0000;
        step(D + LAT + 2);

        // Scenario 5: reset during qualification, button still held afterwards.
        btn_raw = 4'b0010;
        step(2 + LAT);
        resetn = 1'b0;
        step(1);
        chk("s5_reset_outputs", {24'd0, press, press_valid, press_code, multi_err, held}, 32'd0);
        step(1);
        resetn = 1'b1;
        step(D - 1 + LAT);
        chk("s5_full_count", {31'd0, press_valid}, 32'd0);
        step(1);
        chk_event("s5", 4'b0010, 2'd1);
        btn_raw = 4'b0000;
        step(D + LAT + 2);

        chk("total_press_events", pv_cnt, 32'd4);
        chk("total_multi_events", me_cnt, 32'd1);
        chk("pulse_overlap", overlap_cnt, 32'd0);
        chk("pulse_width", wide_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
